maple_tx_seq: RTL and testbench

- Transmit-frame sequencer for the Maple bus output shifter (maple_out).
- Generates the bit-phase tick and issues start/end commands through the shifter's control register port.
- Gates the TX FIFO so the shifter consumes exactly one frame's bytes, then reports completion and errors to the host register block.
- Sits between the host command registers, the TX FIFO and maple_out.

---
 rtl/maple_pkg.sv | 36 +++
 rtl/maple_tick_gen.sv | 49 ++++
 rtl/maple_tx_seq.sv | 192 +++++++++++++++++++
 tb/tb_maple_tx_seq.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maple_pkg.sv
// -----------------------------------------------------------------------------
// maple_pkg
// Shared types and constants for the Maple bus transmit sequencer.
//   state_e      : sequencer FSM states
//   CTRL_*       : command words written to maple_out's control register
//   ST_*_BIT     : bit positions in maple_out's status read-back
//   frame_bytes  : total bytes in a frame for a given header word count
// -----------------------------------------------------------------------------
package maple_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START_CMD,
        START_WAIT,
        DATA,
        END_CMD,
        END_WAIT
    } state_e;

    localparam logic [7:0] CTRL_START = 8'h01;
    localparam logic [7:0] CTRL_END   = 8'h02;

    localparam int ST_START_BIT = 0;
    localparam int ST_END_BIT   = 1;
    localparam int ST_OE_BIT    = 2;

    // One byte on the wire is 8 bits x 4 phases.
    localparam int TICKS_PER_BYTE = 32;
    localparam int PH_W           = $clog2(TICKS_PER_BYTE + 1);

    // N header words describe N+1 words of payload, plus one trailing CRC byte.
    function automatic int unsigned frame_bytes(input logic [7:0] words);
        return 4 * (32'(words) + 1) + 1;
    endfunction

endpackage

// File: rtl/maple_tick_gen.sv
// -----------------------------------------------------------------------------
// maple_tick_gen
// Bit-phase tick divider for maple_out. Counts 0..div and emits a one-clock
// tick on the terminal count, then wraps to 0.
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : counter runs and tick may assert only while high
//   restart    : synchronous clear of the count (frame start)
//   div        : terminal count; tick period is div+1 clocks
//   tick       : one-clock pulse on terminal count
// -----------------------------------------------------------------------------
module maple_tick_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // NOTE: every always_comb output gets a default on entry so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == div) ? '0 : cnt_q + 1'b1;
        end
    end

    // NOTE: flops use non-blocking assignments so every register samples its
    // pre-edge inputs, independent of block ordering in the simulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Decoded straight from the counter flop; div=0 ticks every enabled clock.
    assign tick = enable && (cnt_q == div);

endmodule

// File: rtl/maple_tx_seq.sv
// -----------------------------------------------------------------------------
// maple_tx_seq
// Transmit-frame sequencer for the Maple bus output shifter (maple_out).
// Issues the start pattern, lets the shifter drain exactly one frame's bytes
// from the TX FIFO, issues the end pattern and waits for the bus release.
//   Host side : cmd_go, cmd_words, cmd_abort, tick_div -> busy, done,
//               err_underrun, err_abort (sticky until the next accepted go)
//   maple_out : tick, ctrl_cs/ctrl_we/ctrl_wdata, ctrl_rdata (status),
//               mo_data_avail -> shifter, mo_consume <- shifter
//   TX FIFO   : fifo_avail (not empty)
// -----------------------------------------------------------------------------
module maple_tx_seq
    import maple_pkg::*;
#(
    parameter int DIV_W = 8,
    parameter int LEN_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_go,
    input  logic [7:0]       cmd_words,
    input  logic             cmd_abort,
    input  logic [DIV_W-1:0] tick_div,
    output logic             busy,
    output logic             done,
    output logic             err_underrun,
    output logic             err_abort,
    output logic             tick,
    output logic             ctrl_cs,
    output logic             ctrl_we,
    output logic [7:0]       ctrl_wdata,
    input  logic [7:0]       ctrl_rdata,
    input  logic             fifo_avail,
    output logic             mo_data_avail,
    input  logic             mo_consume
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] bytes_left_q, bytes_left_d;
    logic [PH_W-1:0]  ph_cnt_q, ph_cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_underrun_q, err_underrun_d;
    logic             err_abort_q, err_abort_d;
    logic             ctrl_cs_q, ctrl_cs_d;
    logic             ctrl_we_q, ctrl_we_d;
    logic [7:0]       ctrl_wdata_q, ctrl_wdata_d;

    logic accept;
    logic ph_full;
    logic unused_rdata;

    assign accept  = cmd_go && (state_q == IDLE);
    assign ph_full = (ph_cnt_q == PH_W'(TICKS_PER_BYTE));

    // Only start-active and oe are acted on; the rest of the status is ignored.
    assign unused_rdata = ^{ctrl_rdata[7:3], ctrl_rdata[ST_END_BIT]};

    maple_tick_gen #(
        .DIV_W(DIV_W)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (busy_q),
        .restart(accept),
        .div    (div_q),
        .tick   (tick)
    );

    always_comb begin
        state_d        = state_q;
        bytes_left_d   = bytes_left_q;
        ph_cnt_d       = ph_cnt_q;
        div_d          = div_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        err_underrun_d = err_underrun_q;
        err_abort_d    = err_abort_q;

        if (mo_consume && (bytes_left_q != '0)) begin
            bytes_left_d = bytes_left_q - 1'b1;
        end

        // ph_cnt only lives in DATA, so it is already 0 on DATA entry and a
        // stale value from a previous frame can never trip the byte checks.
        if (state_q != DATA) begin
            ph_cnt_d = '0;
        end else if (mo_consume) begin
            ph_cnt_d = '0;
        end else if (tick && !ph_full) begin
            ph_cnt_d = ph_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (cmd_go) begin
                    state_d        = START_CMD;
                    bytes_left_d   = LEN_W'(frame_bytes(cmd_words));
                    div_d          = tick_div;
                    busy_d         = 1'b1;
                    err_underrun_d = 1'b0;
                    err_abort_d    = 1'b0;
                end
            end
            START_CMD: state_d = START_WAIT;
            START_WAIT: begin
                if (cmd_abort) begin
                    err_abort_d = 1'b1;
                    state_d     = END_CMD;
                end else if (!ctrl_rdata[ST_START_BIT]) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                // Abort and underrun are independent; both flags may set together.
                if (cmd_abort) begin
                    err_abort_d = 1'b1;
                    state_d     = END_CMD;
                end
                if (ph_full) begin
                    if (bytes_left_q == '0) begin
                        state_d = END_CMD;
                    end else if (!fifo_avail) begin
                        err_underrun_d = 1'b1;
                        state_d        = END_CMD;
                    end
                end
            end
            END_CMD: state_d = END_WAIT;
            END_WAIT: begin
                if (!ctrl_rdata[ST_OE_BIT]) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control port outputs are decoded from the next state so the registered
    // strobes line up with the state they belong to, glitch-free.
    always_comb begin
        ctrl_cs_d    = state_d inside {START_CMD, START_WAIT, END_CMD, END_WAIT};
        ctrl_we_d    = state_d inside {START_CMD, END_CMD};
        ctrl_wdata_d = 8'h00;
        if (state_d == START_CMD) begin
            ctrl_wdata_d = CTRL_START;
        end else if (state_d == END_CMD) begin
            ctrl_wdata_d = CTRL_END;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            bytes_left_q   <= '0;
            ph_cnt_q       <= '0;
            div_q          <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_underrun_q <= 1'b0;
            err_abort_q    <= 1'b0;
            ctrl_cs_q      <= 1'b0;
            ctrl_we_q      <= 1'b0;
            ctrl_wdata_q   <= 8'h00;
        end else begin
            state_q        <= state_d;
            bytes_left_q   <= bytes_left_d;
            ph_cnt_q       <= ph_cnt_d;
            div_q          <= div_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_underrun_q <= err_underrun_d;
            err_abort_q    <= err_abort_d;
            ctrl_cs_q      <= ctrl_cs_d;
            ctrl_we_q      <= ctrl_we_d;
            ctrl_wdata_q   <= ctrl_wdata_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err_underrun  = err_underrun_q;
    assign err_abort     = err_abort_q;
    assign ctrl_cs       = ctrl_cs_q;
    assign ctrl_we       = ctrl_we_q;
    assign ctrl_wdata    = ctrl_wdata_q;
    assign mo_data_avail = fifo_avail && (state_q == DATA) && (bytes_left_q != '0);

endmodule

// File: tb/tb_maple_tx_seq.sv
// -----------------------------------------------------------------------------
// tb_maple_tx_seq
// Bench for maple_tx_seq with a behavioural stand-in for maple_out and the
// TX FIFO. Expected control writes and per-frame outcomes are queued when a
// frame is launched and compared when the DUT writes or pulses done.
// -----------------------------------------------------------------------------
module tb_maple_tx_seq;
    import maple_pkg::*;

    localparam int DIV_W = 8;
    localparam int LEN_W = 11;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_go = 1'b0;
    logic [7:0]       cmd_words = 8'd0;
    logic             cmd_abort = 1'b0;
    logic [DIV_W-1:0] tick_div = '0;
    logic             busy, done, err_underrun, err_abort, tick;
    logic             ctrl_cs, ctrl_we;
    logic [7:0]       ctrl_wdata;
    logic [7:0]       ctrl_rdata = 8'h00;
    logic             fifo_avail = 1'b0;
    logic             mo_data_avail;
    logic             mo_consume = 1'b0;

    always #5 clk = ~clk;

    maple_tx_seq #(.DIV_W(DIV_W), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_go       (cmd_go),
        .cmd_words    (cmd_words),
        .cmd_abort    (cmd_abort),
        .tick_div     (tick_div),
        .busy         (busy),
        .done         (done),
        .err_underrun (err_underrun),
        .err_abort    (err_abort),
        .tick         (tick),
        .ctrl_cs      (ctrl_cs),
        .ctrl_we      (ctrl_we),
        .ctrl_wdata   (ctrl_wdata),
        .ctrl_rdata   (ctrl_rdata),
        .fifo_avail   (fifo_avail),
        .mo_data_avail(mo_data_avail),
        .mo_consume   (mo_consume)
    );

    typedef struct {
        int consumes;
        bit underrun;
        bit abort;
        int div;
    } frame_t;

    logic [7:0] exp_wr_q[$];
    frame_t     exp_frame_q[$];

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Stand-in state for maple_out and the FIFO (owned by the monitor process).
    int cyc = 0;
    int fifo_pushed = 0;
    int fifo_popped = 0;
    int shift = 0;
    int frame_consumes = 0;
    int busy_cycles = 0;
    int tick_cnt = 0;
    int tick_stray = 0;
    int consume_idle = 0;
    int done_cnt = 0;
    int start_t = 0;
    int end_t = 0;
    int oe_drop_cyc = -10;
    bit start_active = 1'b0;
    bit end_active = 1'b0;
    bit oe = 1'b0;
    // Abort bookkeeping: main raises abort_req, monitor acknowledges.
    int abort_req = 0;
    int abort_seen = 0;
    int abort_cyc = 0;

    // Runs at every falling edge: observes this cycle's DUT outputs, then
    // drives this cycle's shifter/FIFO responses ahead of the rising edge.
    initial begin
        logic [7:0] exp_wr;
        frame_t     f;
        bit         consume_now;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                exp_wr_q.delete();
                exp_frame_q.delete();
                start_active = 1'b0; end_active = 1'b0; oe = 1'b0;
                start_t = 0; end_t = 0; shift = 0;
                frame_consumes = 0; busy_cycles = 0; tick_cnt = 0;
                mo_consume = 1'b0;
                ctrl_rdata = 8'h00;
                abort_seen = abort_req;
                continue;
            end

            // FIFO pop for the consume sampled at the previous rising edge.
            if (mo_consume) fifo_popped++;
            fifo_avail = (fifo_pushed != fifo_popped);

            if (tick && !busy) tick_stray++;
            if (busy) busy_cycles++;
            if (tick) tick_cnt++;

            if (start_t > 0) begin
                start_t--;
                if (start_t == 0) start_active = 1'b0;
            end
            if (end_t > 0) begin
                end_t--;
                if (end_t == 0) begin
                    end_active  = 1'b0;
                    oe          = 1'b0;
                    oe_drop_cyc = cyc;
                end
            end

            if (ctrl_cs && ctrl_we) begin
                if (exp_wr_q.size() == 0) begin
                    check("wr_extra_pending", exp_wr_q.size(), 1);
                end else begin
                    exp_wr = exp_wr_q.pop_front();
                    check("ctrl_wdata", ctrl_wdata, exp_wr);
                    if (exp_wr == CTRL_END && abort_seen != abort_req) begin
                        check("end_after_abort_cyc", cyc, abort_cyc + 1);
                        abort_seen = abort_req;
                    end
                end
                if (ctrl_wdata[ST_START_BIT]) begin
                    start_active = 1'b1; oe = 1'b1; start_t = 3;
                end
                if (ctrl_wdata[ST_END_BIT]) begin
                    end_active = 1'b1; end_t = 4;
                end
            end

            if (done) begin
                if (exp_frame_q.size() == 0) begin
                    check("done_extra_pending", exp_frame_q.size(), 1);
                end else begin
                    f = exp_frame_q.pop_front();
                    check("consumes", frame_consumes, f.consumes);
                    check("err_underrun", err_underrun, f.underrun);
                    check("err_abort", err_abort, f.abort);
                    check("busy_at_done", busy, 0);
                    check("done_after_oe", cyc - oe_drop_cyc, 1);
                    check("ticks", tick_cnt, busy_cycles / (f.div + 1));
                end
                frame_consumes = 0; busy_cycles = 0; tick_cnt = 0; shift = 0;
                done_cnt++;
            end

            // Shifter: take a byte when offered and idle, then shift 32 ticks.
            consume_now = mo_data_avail && (fifo_pushed != fifo_popped) && (shift == 0);
            if (consume_now) begin
                shift = TICKS_PER_BYTE;
                frame_consumes++;
                if (!busy) consume_idle++;
            end else if (tick && shift > 0) begin
                shift--;
            end
            mo_consume = consume_now;
            ctrl_rdata = {5'b0, oe, end_active, start_active};
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic launch(input logic [7:0] words, input int div, input int fifo_bytes,
                          input int exp_cons, input bit exp_u, input bit exp_a);
        step();
        fifo_pushed += fifo_bytes;
        exp_wr_q.push_back(CTRL_START);
        exp_wr_q.push_back(CTRL_END);
        exp_frame_q.push_back(frame_t'{exp_cons, exp_u, exp_a, div});
        cmd_words = words;
        tick_div  = DIV_W'(div);
        cmd_go    = 1'b1;
        step();
        cmd_go = 1'b0;
        check("busy_on_go", busy, 1);
        check("errs_cleared_on_go", {err_underrun, err_abort}, 0);
    endtask

    task automatic wait_done(input int budget);
        int start = done_cnt;
        int n = 0;
        while (done_cnt == start && n < budget) begin
            step();
            n++;
        end
        check("done_seen", done_cnt - start, 1);
    endtask

    task automatic wait_consumes(input int target, input int budget);
        int n = 0;
        while (frame_consumes < target && n < budget) begin
            step();
            n++;
        end
        check("consumes_reached", frame_consumes, target);
    endtask

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #11;
        check("reset_outputs",
              {busy, done, err_underrun, err_abort, tick, ctrl_cs, ctrl_we, mo_data_avail, ctrl_wdata}, 0);
        step();
        rst_n = 1'b1;
        step();

        // Minimal frame: 5 bytes, all preloaded.
        launch(8'd0, 3, 5, 5, 1'b0, 1'b0);
        wait_done(3000);

        // Underrun: 9-byte frame with only 6 bytes available.
        launch(8'd1, 3, 6, 6, 1'b1, 1'b0);
        wait_done(4000);

        // Abort while idle is ignored; the sticky underrun survives.
        step();
        cmd_abort = 1'b1;
        step();
        cmd_abort = 1'b0;
        step();
        check("idle_abort_busy", busy, 0);
        check("idle_abort_flags", {err_underrun, err_abort}, 2'b10);
        check("idle_abort_cs", ctrl_cs, 0);

        // go during DATA ignored, then abort after the second consume.
        launch(8'd3, 1, 100, 2, 1'b0, 1'b1);
        wait_consumes(1, 500);
        cmd_words = 8'd9;
        tick_div  = DIV_W'(5);
        cmd_go    = 1'b1;
        step();
        cmd_go = 1'b0;
        check("go_in_data_busy", busy, 1);
        check("go_in_data_flags", {err_underrun, err_abort}, 0);
        wait_consumes(2, 500);
        cmd_abort = 1'b1;
        abort_cyc = cyc;
        abort_req++;
        step();
        cmd_abort = 1'b0;
        wait_done(500);
        fifo_pushed = fifo_popped;

        // Longest frame, FIFO kept fed, tick every clock.
        launch(8'd255, 0, 2000, 1025, 1'b0, 1'b0);
        wait_consumes(1025, 40000);
        step();
        check("avail_after_last_fifo", fifo_avail, 1);
        check("avail_after_last", mo_data_avail, 0);
        check("busy_after_last", busy, 1);
        wait_done(500);
        fifo_pushed = fifo_popped;

        // Asynchronous reset mid-DATA, then a normal frame.
        launch(8'd3, 2, 100, 0, 1'b0, 1'b0);
        wait_consumes(3, 1000);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_outputs",
              {busy, done, err_underrun, err_abort, tick, ctrl_cs, ctrl_we, mo_data_avail, ctrl_wdata}, 0);
        step();
        step();
        rst_n = 1'b1;
        fifo_pushed = fifo_popped;
        launch(8'd2, 0, 13, 13, 1'b0, 1'b0);
        wait_done(2000);

        repeat (3) step();
        check("sb_writes_left", exp_wr_q.size(), 0);
        check("sb_frames_left", exp_frame_q.size(), 0);
        check("tick_while_idle", tick_stray, 0);
        check("consume_while_idle", consume_idle, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
